sad_wta_disparity: RTL and testbench

Winner-take-all disparity selector that consumes the SAD cost-volume stream produced by the stereo SAD stage and emits one disparity per pixel as an AXI4-Stream video beat. Each input beat carries `MAX_SAMPLES_PER_CLOCK` pixels, each with `MAX_DISP` costs. For each pixel the block selects the index of the minimum cost through a registered reduction pipeline, then packs the indices back into a standard video `tdata` word. Sideband signals travel with the data, and framing errors are reported on sticky flags.

---
 rtl/stereo_pkg.sv | 24 ++
 rtl/sad_wta_argmin_tree.sv | 78 +++++++
 rtl/sad_wta_disparity.sv | 126 ++++++++++++
 tb/tb_sad_wta_disparity.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stereo_pkg.sv
// Shared stereo-pipeline types and size helpers used by the SAD and WTA stages.
package stereo_pkg;

  localparam int unsigned COST_W = 8;
  localparam int unsigned DISP_W = 6;

  typedef logic [COST_W-1:0] cost_t;

  typedef struct packed {
    cost_t             cost;
    logic [DISP_W-1:0] index;
  } disp_pair_t;

  // Number of pairwise reduction stages needed to reach a single winner.
  function automatic int unsigned stages_f(input int unsigned max_disp);
    return $clog2(max_disp);
  endfunction

  // Number of beats that make up one video line.
  function automatic int unsigned beats_f(input int unsigned width, input int unsigned spc);
    return width / spc;
  endfunction

endpackage

// File: rtl/sad_wta_argmin_tree.sv
// Pipelined argmin over one pixel's cost vector; ties resolve to the lowest index.
module argmin_tree
  import stereo_pkg::*;
#(
  parameter int unsigned MAX_DISP   = 64,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [MAX_DISP-1:0][DATA_WIDTH-1:0]  costs_i,
  output logic [stages_f(MAX_DISP)-1:0]        idx_o
);

  localparam int unsigned STAGES = stages_f(MAX_DISP);

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    localparam int unsigned N = MAX_DISP >> k;

    logic [2*N-1:0][DATA_WIDTH-1:0] in_cost;
    logic [N-1:0]                   take_hi;
    logic [N-1:0][k-1:0]            idx_q;

    // Odd candidate wins only on a strictly smaller cost.
    always_comb begin
      take_hi = '0;
      for (int i = 0; i < int'(N); i++) begin
        take_hi[i] = in_cost[2*i+1] < in_cost[2*i];
      end
    end

    if (k == 1) begin : g_src
      assign in_cost = costs_i;

      // First stage: index is just the winning side of each pair.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          idx_q <= '0;
        end else begin
          for (int i = 0; i < int'(N); i++) begin
            idx_q[i] <= take_hi[i];
          end
        end
      end
    end else begin : g_src
      assign in_cost = g_stage[k-1].g_cost.cost_q;

      // Later stages prepend the side bit to the surviving index.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          idx_q <= '0;
        end else begin
          for (int i = 0; i < int'(N); i++) begin
            idx_q[i] <= take_hi[i] ? {1'b1, g_stage[k-1].idx_q[2*i+1]}
                                   : {1'b0, g_stage[k-1].idx_q[2*i]};
          end
        end
      end
    end

    if (k < STAGES) begin : g_cost
      logic [N-1:0][DATA_WIDTH-1:0] cost_q;

      // Carry the surviving cost forward; the final stage needs only the index.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cost_q <= '0;
        end else begin
          for (int i = 0; i < int'(N); i++) begin
            cost_q[i] <= take_hi[i] ? in_cost[2*i+1] : in_cost[2*i];
          end
        end
      end
    end
  end

  assign idx_o = g_stage[STAGES].idx_q[0];

endmodule

// File: rtl/sad_wta_disparity.sv
// Winner-take-all disparity selection with sideband alignment and line-length checking.
module sad_wta_disparity
  import stereo_pkg::*;
#(
  parameter int unsigned WIDTH                 = 740,
  parameter int unsigned MAX_DISP              = 64,
  parameter int unsigned MAX_SAMPLES_PER_CLOCK = 4,
  parameter int unsigned DATA_WIDTH            = 8,
  parameter int unsigned AXIS_TDATA_WIDTH      = 32
) (
  input  logic                                 aclk,
  input  logic                                 areset,
  input  logic [MAX_DISP-1:0][DATA_WIDTH-1:0]  s_axis_tdata [MAX_SAMPLES_PER_CLOCK],
  input  logic                                 s_axis_tvalid,
  input  logic                                 s_axis_tlast,
  input  logic                                 s_axis_tuser,
  output logic [AXIS_TDATA_WIDTH-1:0]          m_axis_video_tdata,
  output logic                                 m_axis_video_tvalid,
  output logic                                 m_axis_video_tlast,
  output logic                                 m_axis_video_tuser,
  output logic                                 err_short_line,
  output logic                                 err_long_line
);

  localparam int unsigned STAGES = stages_f(MAX_DISP);
  localparam int unsigned BEATS  = beats_f(WIDTH, MAX_SAMPLES_PER_CLOCK);
  localparam int unsigned CNT_W  = $clog2(BEATS) + 1;
  localparam int unsigned NUM_W  = CNT_W + 1;

  logic [STAGES-1:0]           idx [MAX_SAMPLES_PER_CLOCK];
  logic [STAGES-1:0]           vld_q, last_q, user_q;
  logic [AXIS_TDATA_WIDTH-1:0] tdata_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [NUM_W-1:0]            beat_num;
  logic                        short_d, long_d;

  for (genvar p = 0; p < MAX_SAMPLES_PER_CLOCK; p++) begin : g_pix
    argmin_tree #(
      .MAX_DISP   (MAX_DISP),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_tree (
      .clk_i   (aclk),
      .rst_i   (areset),
      .costs_i (s_axis_tdata[p]),
      .idx_o   (idx[p])
    );
  end

  // Sideband delay line matching the reduction depth.
  always_ff @(posedge aclk) begin
    if (areset) begin
      vld_q  <= '0;
      last_q <= '0;
      user_q <= '0;
    end else begin
      vld_q[0]  <= s_axis_tvalid;
      last_q[0] <= s_axis_tvalid & s_axis_tlast;
      user_q[0] <= s_axis_tvalid & s_axis_tuser;
      for (int i = 1; i < int'(STAGES); i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
        user_q[i] <= user_q[i-1];
      end
    end
  end

  // Zero-extend each pixel's disparity into its output lane.
  always_comb begin
    tdata_d = '0;
    for (int p = 0; p < int'(MAX_SAMPLES_PER_CLOCK); p++) begin
      tdata_d[p*DATA_WIDTH +: STAGES] = idx[p];
    end
  end

  // Output register stage.
  always_ff @(posedge aclk) begin
    if (areset) begin
      m_axis_video_tdata  <= '0;
      m_axis_video_tvalid <= 1'b0;
      m_axis_video_tlast  <= 1'b0;
      m_axis_video_tuser  <= 1'b0;
    end else begin
      m_axis_video_tdata  <= tdata_d;
      m_axis_video_tvalid <= vld_q[STAGES-1];
      m_axis_video_tlast  <= last_q[STAGES-1];
      m_axis_video_tuser  <= user_q[STAGES-1];
    end
  end

  // Line checker: tuser restarts numbering at beat 1; cnt saturates one past a full line.
  always_comb begin
    cnt_d    = cnt_q;
    short_d  = err_short_line;
    long_d   = err_long_line;
    beat_num = s_axis_tuser ? NUM_W'(1) : NUM_W'(cnt_q) + NUM_W'(1);
    if (s_axis_tvalid) begin
      if (s_axis_tlast) begin
        cnt_d = '0;
        if (beat_num > NUM_W'(BEATS)) begin
          long_d = 1'b1;
        end else if (beat_num != NUM_W'(BEATS)) begin
          short_d = 1'b1;
        end
      end else begin
        if (beat_num == NUM_W'(BEATS + 1)) begin
          long_d = 1'b1;
        end
        cnt_d = (beat_num > NUM_W'(BEATS + 1)) ? CNT_W'(BEATS + 1) : CNT_W'(beat_num);
      end
    end
  end

  // Beat counter and sticky error flags.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q          <= '0;
      err_short_line <= 1'b0;
      err_long_line  <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      err_short_line <= short_d;
      err_long_line  <= long_d;
    end
  end

endmodule

// File: tb/tb_sad_wta_disparity.sv
// Randomized and directed checking of sad_wta_disparity against a behavioural argmin model.
module tb_sad_wta_disparity;

  localparam int unsigned WIDTH = 740;
  localparam int unsigned MAX_DISP = 64;
  localparam int unsigned SPC = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned TW = 32;
  localparam int BEATS = 185;
  localparam int LAT = 7;

  logic aclk;
  logic areset;
  logic [MAX_DISP-1:0][DW-1:0] s_axis_tdata [SPC];
  logic s_axis_tvalid, s_axis_tlast, s_axis_tuser;
  logic [TW-1:0] m_axis_video_tdata;
  logic m_axis_video_tvalid, m_axis_video_tlast, m_axis_video_tuser;
  logic err_short_line, err_long_line;

  int assertions = 0;
  int failures = 0;
  bit chk_en = 0;

  sad_wta_disparity #(
    .WIDTH                 (WIDTH),
    .MAX_DISP              (MAX_DISP),
    .MAX_SAMPLES_PER_CLOCK (SPC),
    .DATA_WIDTH            (DW),
    .AXIS_TDATA_WIDTH      (TW)
  ) dut (
    .aclk                (aclk),
    .areset              (areset),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tlast        (s_axis_tlast),
    .s_axis_tuser        (s_axis_tuser),
    .m_axis_video_tdata  (m_axis_video_tdata),
    .m_axis_video_tvalid (m_axis_video_tvalid),
    .m_axis_video_tlast  (m_axis_video_tlast),
    .m_axis_video_tuser  (m_axis_video_tuser),
    .err_short_line      (err_short_line),
    .err_long_line       (err_long_line)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain linear scan: first strictly smaller cost wins.
  function automatic int argmin(input logic [MAX_DISP-1:0][DW-1:0] c);
    int best = 0;
    for (int d = 1; d < int'(MAX_DISP); d++) begin
      if (c[d] < c[best]) best = d;
    end
    return best;
  endfunction

  typedef struct packed {
    logic        v;
    logic        l;
    logic        u;
    logic [31:0] d;
  } exp_t;

  exp_t pipe[$];
  int   pos = 0;
  bit   e_short = 0, e_long = 0;
  bit   rst_prev = 0;

  // Reference model and per-cycle comparison, sampled mid-cycle.
  always @(negedge aclk) begin
    exp_t e, x;
    if (chk_en) begin
      e = '0;
      e.v = s_axis_tvalid;
      e.l = s_axis_tvalid & s_axis_tlast;
      e.u = s_axis_tvalid & s_axis_tuser;
      for (int p = 0; p < int'(SPC); p++) e.d[p*8 +: 8] = 8'(argmin(s_axis_tdata[p]));
      pipe.push_back(e);
      x = pipe.pop_front();
      chk("tvalid", 64'(m_axis_video_tvalid), 64'(x.v));
      chk("tlast", 64'(m_axis_video_tlast), 64'(x.l));
      chk("tuser", 64'(m_axis_video_tuser), 64'(x.u));
      if (x.v) chk("tdata", 64'(m_axis_video_tdata), 64'(x.d));
      if (rst_prev) chk("tdata_rst", 64'(m_axis_video_tdata), 64'd0);
      chk("err_short", 64'(err_short_line), 64'(e_short));
      chk("err_long", 64'(err_long_line), 64'(e_long));
    end
    rst_prev = areset;
    if (areset) begin
      pipe.delete();
      repeat (LAT) pipe.push_back(exp_t'('0));
      pos = 0;
      e_short = 0;
      e_long = 0;
    end else if (s_axis_tvalid) begin
      pos = s_axis_tuser ? 1 : pos + 1;
      if (s_axis_tlast) begin
        if (pos > BEATS) e_long = 1;
        else if (pos < BEATS) e_short = 1;
        pos = 0;
      end else if (pos == BEATS + 1) begin
        e_long = 1;
      end
    end
  end

  task automatic drive(input bit v, input bit l, input bit u);
    s_axis_tvalid = v;
    s_axis_tlast = l;
    s_axis_tuser = u;
    @(posedge aclk);
    #1;
  endtask

  task automatic fill_all(input logic [7:0] val);
    for (int p = 0; p < int'(SPC); p++)
      for (int d = 0; d < int'(MAX_DISP); d++) s_axis_tdata[p][d] = val;
  endtask

  task automatic fill_random();
    for (int p = 0; p < int'(SPC); p++) begin
      int mode = $urandom_range(0, 3);
      logic [7:0] base = 8'($urandom_range(0, 255));
      for (int d = 0; d < int'(MAX_DISP); d++) begin
        case (mode)
          0: s_axis_tdata[p][d] = 8'($urandom_range(0, 255));
          1: s_axis_tdata[p][d] = 8'($urandom_range(0, 3));
          2: s_axis_tdata[p][d] = 8'd255;
          default: s_axis_tdata[p][d] = base;
        endcase
      end
      if (mode == 2) s_axis_tdata[p][$urandom_range(0, 63)] = 8'($urandom_range(0, 254));
    end
  endtask

  // One isolated beat; checks latency and packed lanes against a literal.
  task automatic pin_beat(input string name, input logic [31:0] exp_d);
    int n = 0;
    bit got = 0;
    drive(1, 0, 0);
    s_axis_tvalid = 0;
    while (!got && n < 20) begin
      @(negedge aclk);
      n++;
      if (m_axis_video_tvalid) got = 1;
    end
    chk({name, "_latency"}, 64'(n), 64'(LAT));
    chk({name, "_tdata"}, 64'(m_axis_video_tdata), 64'(exp_d));
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int nv;
    areset = 1;
    s_axis_tvalid = 0;
    s_axis_tlast = 0;
    s_axis_tuser = 0;
    fill_all(8'd0);
    @(posedge aclk);
    #1;
    chk_en = 1;
    chk("rst_tvalid", 64'(m_axis_video_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_axis_video_tdata), 64'd0);
    chk("rst_flags", 64'({err_short_line, err_long_line}), 64'd0);
    repeat (2) @(posedge aclk);
    #1;
    areset = 0;

    // Isolated beats with hand-computed results.
    fill_all(8'd255);
    s_axis_tdata[0][17] = 8'd3;
    pin_beat("pin_d17", 32'h0000_0011);
    fill_all(8'd100);
    pin_beat("pin_alleq", 32'h0000_0000);
    fill_all(8'd200);
    s_axis_tdata[0][5] = 8'd7;
    s_axis_tdata[0][40] = 8'd7;
    for (int d = 0; d < 64; d++) begin
      s_axis_tdata[1][d] = 8'd255;
      s_axis_tdata[2][d] = 8'd255;
      s_axis_tdata[3][d] = 8'd0;
    end
    s_axis_tdata[1][63] = 8'd0;
    s_axis_tdata[2][62] = 8'd254;
    pin_beat("pin_mixed", 32'h003E_3F05);

    // Full line of back-to-back beats with a known disparity ramp.
    for (int b = 1; b <= BEATS; b++) begin
      fill_all(8'd255);
      for (int p = 0; p < 4; p++) s_axis_tdata[p][(b + p) % 64] = 8'd10;
      drive(1, b == BEATS, b == 1);
    end
    chk("full_line_flags", 64'({err_short_line, err_long_line}), 64'd0);

    // Short line then long line.
    for (int b = 1; b <= 100; b++) begin
      fill_random();
      drive(1, b == 100, b == 1);
      if (b == 99) chk("short_early", 64'(err_short_line), 64'd0);
    end
    chk("short_set", 64'(err_short_line), 64'd1);
    for (int b = 1; b <= 186; b++) begin
      fill_random();
      drive(1, b == 186, b == 1);
      if (b == 185) chk("long_early", 64'(err_long_line), 64'd0);
    end
    chk("long_set", 64'(err_long_line), 64'd1);
    chk("short_sticky", 64'(err_short_line), 64'd1);
    repeat (8) drive(0, 0, 0);

    // Reset with six beats in flight.
    for (int b = 1; b <= 6; b++) begin
      fill_random();
      drive(1, 0, b == 1);
    end
    areset = 1;
    drive(0, 0, 0);
    areset = 0;
    chk("mid_rst_flags", 64'({err_short_line, err_long_line}), 64'd0);
    chk("mid_rst_tdata", 64'(m_axis_video_tdata), 64'd0);
    nv = 0;
    repeat (LAT) begin
      @(negedge aclk);
      if (m_axis_video_tvalid) nv++;
    end
    chk("post_rst_quiet", 64'(nv), 64'd0);
    @(posedge aclk);
    #1;
    for (int b = 1; b <= BEATS; b++) begin
      fill_random();
      drive(1, b == BEATS, 0);
    end
    chk("post_rst_line_flags", 64'({err_short_line, err_long_line}), 64'd0);

    // Two frames with random idle gaps.
    for (int f = 0; f < 2; f++) begin
      for (int ln = 0; ln < 3; ln++) begin
        for (int b = 1; b <= BEATS; b++) begin
          while ($urandom_range(0, 99) < 30) begin
            fill_random();
            drive(0, 0, 0);
          end
          fill_random();
          drive(1, b == BEATS, ln == 0 && b == 1);
        end
      end
    end
    repeat (12) drive(0, 0, 0);
    chk("final_flags", 64'({err_short_line, err_long_line}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
